// File: rtl/des_pkg.sv
// Shared definitions for the DES stream sequencer.
//   DES_BLOCK_W     : width of one DES block (64 bits)
//   des_seq_state_t : sequencer FSM states
package des_pkg;

  localparam int unsigned DES_BLOCK_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_LAUNCH,
    S_WAIT_DES,
    S_WRITE
  } des_seq_state_t;

endpackage

// File: rtl/des_stream_sequencer_if.sv
// Bundle of control, input-BRAM, DES-core and output-BRAM signals around the
// DES stream sequencer.
//   master : sequencer side (drives BRAM/DES requests and status)
//   slave  : environment side (control registers, BRAMs, DES core)
interface des_stream_sequencer_if
  import des_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);

  // control / status
  logic                   start;
  logic [ADDR_W:0]        num_blocks;
  logic                   busy;
  logic                   done;
  logic                   error;
  // input BRAM
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DES_BLOCK_W-1:0] rd_data;
  // DES core
  logic                   des_start;
  logic [DES_BLOCK_W-1:0] des_din;
  logic                   des_done;
  logic [DES_BLOCK_W-1:0] des_dout;
  // output BRAM
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DES_BLOCK_W-1:0] wr_data;

  modport master (
    input  start, num_blocks, rd_data, des_done, des_dout,
    output busy, done, error, rd_en, rd_addr, des_start, des_din,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, num_blocks, rd_data, des_done, des_dout,
    input  busy, done, error, rd_en, rd_addr, des_start, des_din,
           wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/des_stream_sequencer.sv
// DES stream sequencer: for each block index of a batch, reads the input
// BRAM, waits the BRAM read latency, launches the DES core, waits for its
// done pulse (with timeout) and writes the result to the output BRAM at the
// same index.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : des_stream_sequencer_if.master (control/status, BRAM, DES signals)
// Parameters: ADDR_W (BRAM address width), RD_LAT (read latency, 1..3),
// TIMEOUT (cycles to wait for des_done, >= 1). ADDR_W must match the
// interface instance.
module des_stream_sequencer
  import des_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  des_stream_sequencer_if.master bus
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_BLOCKS = {1'b1, {ADDR_W{1'b0}}};

  des_seq_state_t    state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   count;
  logic [1:0]        wcnt;
  logic [TW-1:0]     tcnt;

  assign bus.busy = (state != S_IDLE);

  // All handshake outputs are registered: each is set on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      count         <= '0;
      wcnt          <= '0;
      tcnt          <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.des_start <= 1'b0;
      bus.des_din   <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.rd_en     <= 1'b0;
      bus.des_start <= 1'b0;
      bus.wr_en     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            idx       <= '0;
            count     <= (bus.num_blocks > MAX_BLOCKS) ? MAX_BLOCKS : bus.num_blocks;
            bus.error <= 1'b0;
            if (bus.num_blocks == '0) begin
              bus.done <= 1'b1;
            end else begin
              bus.done    <= 1'b0;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= '0;
              state       <= S_READ;
            end
          end
        end
        S_READ: begin
          wcnt  <= '0;
          state <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          // des_din doubles as the block register; it stays put until the
          // next capture, so it is stable across the whole DES operation.
          if (wcnt == 2'(RD_LAT - 1)) begin
            bus.des_din   <= bus.rd_data;
            bus.des_start <= 1'b1;
            state         <= S_LAUNCH;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT_DES;
        end
        S_WAIT_DES: begin
          if (bus.des_done) begin
            bus.wr_data <= bus.des_dout;
            bus.wr_addr <= idx;
            bus.wr_en   <= 1'b1;
            state       <= S_WRITE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            bus.error <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WRITE: begin
          if ({1'b0, idx} == count - (ADDR_W + 1)'(1)) begin
            bus.done <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idx         <= idx + ADDR_W'(1);
            bus.rd_addr <= idx + ADDR_W'(1);
            bus.rd_en   <= 1'b1;
            state       <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/des_stream_sequencer.md
# des_stream_sequencer

Sequences a batch of 64-bit blocks through the DES core: reads each block from the input BRAM, launches the DES engine with a start/done handshake, and writes the result to the output BRAM at the same index. It sits between the PS-facing control registers (start, block count, status) and the BRAM/DES datapath, and replaces free-running address generation with a per-block, handshake-driven schedule.

## Interface
- ADDR_W, 10, BRAM address width; depth = 2**ADDR_W blocks
- RD_LAT, 2, input BRAM read latency in cycles (1..3)
- TIMEOUT, 255, max cycles to wait for des_done before abort (≥ 1)

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a batch; ignored while busy
- num_blocks  in  ADDR_W+1  blocks in batch, sampled on accepted start; values > 2**ADDR_W clamp to 2**ADDR_W
- rd_en  out  1  input BRAM read enable
- rd_addr  out  ADDR_W  input BRAM address
- rd_data  in  64  input BRAM data, valid RD_LAT cycles after rd_en
- des_start  out  1  one-cycle pulse launching the DES core
- des_din  out  64  block to DES core, held stable from des_start until des_done
- des_done  in  1  one-cycle pulse from DES core, des_dout valid same cycle
- des_dout  in  64  DES result
- wr_en  out  1  output BRAM write enable
- wr_addr  out  ADDR_W  output BRAM address
- wr_data  out  64  output BRAM data
- busy  out  1  high while a batch is in progress
- done  out  1  sticky: batch completed; cleared on next accepted start or reset
- error  out  1  sticky: DES timeout abort; cleared on next accepted start or reset

## Operation
- States: IDLE, READ, WAIT_RD, LAUNCH, WAIT_DES, WRITE.
- IDLE: start=1 → latch count (clamped), idx=0, clear done/error; count=0 → set done, stay IDLE, no BRAM/DES activity; else → READ.
- READ: rd_en=1, rd_addr=idx, one cycle → WAIT_RD.
- WAIT_RD: RD_LAT cycles; rd_data captured into block register on the last one → LAUNCH.
- LAUNCH: des_start=1, des_din=block register, one cycle → WAIT_DES; timeout counter cleared.
- WAIT_DES: des_done=1 → capture des_dout → WRITE; counter reaches TIMEOUT first → set error, → IDLE (done stays 0).
- WRITE: wr_en=1, wr_addr=idx, wr_data=captured result; idx==count-1 → set done, → IDLE; else idx+1 → READ.
- des_done outside WAIT_DES ignored; start while busy ignored (count not re-sampled).
- rd_en, wr_en, des_start are never high in the same cycle.
- reset low at any time: immediately state IDLE; all outputs 0 (rd_addr, wr_addr, des_din, wr_data = 0); idx, count, counters = 0; in-flight block dropped.
- busy = (state != IDLE).

## Timing
- start accepted at edge E → READ in cycle E+1; busy high from E+1.
- Per block, DES latency L (des_done L ≥ 1 cycles after des_start): READ at t, capture at t+RD_LAT, des_start at t+RD_LAT+1, des_done at t+RD_LAT+1+L, wr_en at t+RD_LAT+2+L, next READ at t+RD_LAT+3+L.
- Batch of N blocks: N·(RD_LAT+L+3) cycles from first READ to end of last WRITE; done and busy=0 from the next cycle.
- Timeout: error set at the edge where WAIT_DES has lasted TIMEOUT cycles without des_done.

## Structure
- Shared package des_pkg: DES_BLOCK_W=64, state enumeration des_seq_state_t.
- Single module; no sub-module. Block index, wait counter and timeout counter live inline.

## Test plan
- num_blocks=4, RD_LAT=2, DES model L=16, memory holds 0x0123456789ABCDEF.. → 4 writes at addr 0..3 with model results, done=1 after exactly 4·21 cycles, busy then 0.
- num_blocks=0 → done=1 next cycle, no rd_en/des_start/wr_en ever asserted.
- num_blocks=1025 → clamped to 1024; last write at addr 1023, no address wrap to 0.
- DES model never returns des_done, TIMEOUT=255 → error=1, done=0, no wr_en, state IDLE; next start clears error.
- reset pulsed low in WAIT_DES of block 2 → all outputs 0 asynchronously; later des_done ignored; new start of 3 blocks writes addr 0..2.
- start pulsed mid-batch with different num_blocks → ignored; original count completes unchanged.
